// File: rtl/mux_store_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_store_scan: registered channel mux with direct, hold and scan modes. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_store_scan #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4,
  parameter int DWELL  = 2,
  localparam int SELW  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH*NUM_IN-1:0] d_in,
  input  logic [SELW-1:0]         sel,
  input  logic                    enb_n,
  input  logic [1:0]              mode,
  input  logic                    load,
  output logic [WIDTH-1:0]        q,
  output logic [SELW-1:0]         q_ch,
  output logic                    q_valid,
  output logic                    scan_wrap
);

  localparam logic [1:0]      c_MODE_DIRECT = 2'b00;
  localparam logic [1:0]      c_MODE_SCAN   = 2'b10;
  localparam logic [SELW-1:0] c_LAST_CH     = SELW'(NUM_IN - 1);
  localparam logic [7:0]      c_LAST_DW     = 8'(DWELL - 1);

  logic [WIDTH-1:0] r_q;
  logic [SELW-1:0]  r_q_ch;
  logic             r_q_valid;
  logic             r_scan_wrap;
  logic [SELW-1:0]  r_ch_cnt;
  logic [7:0]       r_dw_cnt;

  logic [WIDTH-1:0] w_dir_data;
  logic [WIDTH-1:0] w_scan_data;
  logic [WIDTH-1:0] w_q_nx;
  logic [SELW-1:0]  w_q_ch_nx;
  logic             w_q_valid_nx;
  logic             w_scan_wrap_nx;
  logic [SELW-1:0]  w_ch_cnt_nx;
  logic [7:0]       w_dw_cnt_nx;

  // Select codes with no matching channel fall through to zero data.
  always_comb begin
    w_dir_data  = '0;
    w_scan_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SELW'(i))
        w_dir_data = d_in[i*WIDTH +: WIDTH];
      if (r_ch_cnt == SELW'(i))
        w_scan_data = d_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_q_nx         = r_q;
    w_q_ch_nx      = r_q_ch;
    w_q_valid_nx   = 1'b0;
    w_scan_wrap_nx = 1'b0;
    w_ch_cnt_nx    = r_ch_cnt;
    w_dw_cnt_nx    = r_dw_cnt;
    if (enb_n) begin
      // Blanking: counters keep their values so the scan resumes in place.
      w_q_nx = '0;
    end else begin
      case (mode)
        c_MODE_DIRECT: begin
          w_ch_cnt_nx = '0;
          w_dw_cnt_nx = '0;
          if (load) begin
            w_q_nx       = w_dir_data;
            w_q_ch_nx    = sel;
            w_q_valid_nx = 1'b1;
          end
        end
        c_MODE_SCAN: begin
          if (r_dw_cnt == c_LAST_DW) begin
            w_q_nx         = w_scan_data;
            w_q_ch_nx      = r_ch_cnt;
            w_q_valid_nx   = 1'b1;
            w_scan_wrap_nx = (r_ch_cnt == c_LAST_CH);
            w_dw_cnt_nx    = '0;
            w_ch_cnt_nx    = (r_ch_cnt == c_LAST_CH) ? '0 : r_ch_cnt + 1'b1;
          end else begin
            w_dw_cnt_nx = r_dw_cnt + 8'd1;
          end
        end
        default: begin
          w_ch_cnt_nx = '0;
          w_dw_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q         <= '0;
      r_q_ch      <= '0;
      r_q_valid   <= 1'b0;
      r_scan_wrap <= 1'b0;
      r_ch_cnt    <= '0;
      r_dw_cnt    <= '0;
    end else begin
      r_q         <= w_q_nx;
      r_q_ch      <= w_q_ch_nx;
      r_q_valid   <= w_q_valid_nx;
      r_scan_wrap <= w_scan_wrap_nx;
      r_ch_cnt    <= w_ch_cnt_nx;
      r_dw_cnt    <= w_dw_cnt_nx;
    end
  end

  assign q         = r_q;
  assign q_ch      = r_q_ch;
  assign q_valid   = r_q_valid;
  assign scan_wrap = r_scan_wrap;

endmodule
`default_nettype wire

// File: doc/mux_store_scan.md
MUX_STORE_SCAN -- requirements
Module: mux_store_scan

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each input channel and of q.
REQ-002 Parameter NUM_IN, default 4: number of input channels, range 2..16.
REQ-003 Parameter DWELL, default 2: cycles per channel in scan mode, range 1..255.
REQ-004 Derived SELW = max(1, ceil(log2(NUM_IN))); not user-settable.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 d_in  in  WIDTH*NUM_IN  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 sel  in  SELW  channel select for direct mode.
REQ-009 enb_n  in  1  active-low strobe; high forces the blanking behaviour.
REQ-010 mode  in  2  00 direct, 01 hold, 10 scan, 11 treated as hold.
REQ-011 load  in  1  capture request, used in direct mode only.
REQ-012 q  out  WIDTH  registered selected data.
REQ-013 q_ch  out  SELW  channel index that produced the current q.
REQ-014 q_valid  out  1  one-cycle pulse: q/q_ch updated by a capture this cycle.
REQ-015 scan_wrap  out  1  one-cycle pulse: last channel captured in scan mode.

Function
REQ-016 All outputs SHALL be registered; capture latency is 1 clk from the sampling edge.
REQ-017 Priority order SHALL be: reset_n low, then enb_n high, then mode.
REQ-018 enb_n high SHALL load q=0, keep q_ch, clear q_valid and scan_wrap, and freeze the scan counters.
REQ-019 Direct, load=1, sel<NUM_IN: q<=d_in[sel], q_ch<=sel, q_valid<=1.
REQ-020 Direct, load=1, sel>=NUM_IN: q<=0, q_ch<=sel, q_valid<=1.
REQ-021 Direct, load=0: q and q_ch hold; q_valid<=0.
REQ-022 Hold (01 or 11): q and q_ch hold; q_valid<=0; scan_wrap<=0; load and sel ignored.
REQ-023 Scan mode SHALL keep a channel counter ch_cnt (0..NUM_IN-1) and a dwell counter dw_cnt (0..DWELL-1).
REQ-024 In scan mode, dw_cnt SHALL increment each enabled cycle and wrap to 0 after DWELL-1.
REQ-025 Scan capture occurs on the edge where dw_cnt==DWELL-1: q<=d_in[ch_cnt], q_ch<=ch_cnt, q_valid<=1, ch_cnt advances.
REQ-026 ch_cnt SHALL wrap from NUM_IN-1 to 0; scan_wrap SHALL pulse with the capture of channel NUM_IN-1.
REQ-027 On any cycle where mode is not scan, ch_cnt and dw_cnt SHALL clear to 0.
REQ-028 Entering scan therefore yields the first capture (channel 0) DWELL cycles after mode first reads 10.
REQ-029 Non-capture scan cycles SHALL hold q and q_ch with q_valid=0 and scan_wrap=0.
REQ-030 With DWELL=1, every enabled scan cycle SHALL capture the next channel.
REQ-031 Mode changes take effect on the same edge they are sampled; no partial capture is retained.
REQ-032 enb_n returning low mid-scan SHALL resume from the frozen ch_cnt/dw_cnt values.

Reset
REQ-033 reset_n low SHALL immediately force q=0, q_ch=0, q_valid=0, scan_wrap=0, ch_cnt=0, dw_cnt=0.
REQ-034 Reset deassertion SHALL take effect at the next rising clk; the first capture is possible on that edge.
REQ-035 Reset asserted mid-scan SHALL abandon the scan; after release the scan restarts at channel 0.

Verification (WIDTH=4, NUM_IN=4, DWELL=2; d_in ch0..3 = 1,2,3,4 unless stated)
REQ-036 Direct mode, sel=2, load=1 for one cycle -> next cycle q=3, q_ch=2, q_valid=1; following cycle q_valid=0, q=3.
REQ-037 Direct mode, NUM_IN=3 build, sel=3, load=1 -> q=0, q_ch=3, q_valid=1.
REQ-038 Scan for 8 cycles -> captures 1,2,3,4 on cycles 2,4,6,8; scan_wrap=1 only with q=4; the next capture is q=1.
REQ-039 Scan, enb_n=1 for 3 cycles after the second capture -> q=0 and q_valid=0 throughout; after release the next capture is q=3, two cycles later.
REQ-040 Scan interrupted by mode=01 for one cycle, then mode=10 -> q holds during hold; the next capture is channel 0, two cycles after re-entry.
REQ-041 reset_n pulsed low asynchronously between edges mid-scan -> all outputs 0 at once; after release, the first scan capture is q=1.
